sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning frame length in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, frame-start request; honoured only in IDLE.
REQ-005 The block SHALL have port sin, input, 1 bit, serial data bit, sampled once per cycle in SHIFT.
REQ-006 The block SHALL have port out_ready, input, 1 bit, consumer ready to take pout.
REQ-007 The block SHALL have port clr_ovr, input, 1 bit, synchronous clear of overrun.
REQ-008 The block SHALL have port pout, output, WIDTH bits, last completed frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit, pout holds an unconsumed frame.
REQ-010 The block SHALL have port busy, output, 1 bit, high while state is SHIFT.
REQ-011 The block SHALL have port overrun, output, 1 bit, sticky flag: a completed frame was dropped.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 IDLE -> SHIFT on an edge with start=1; the bit counter clears to 0; sin is not sampled on that edge.
REQ-014 In SHIFT, each edge SHALL shift sin into the shift register at bit WIDTH-1, move existing bits toward bit 0, and increment the counter.
REQ-015 The first bit received SHALL end in pout[0]; the last bit received SHALL end in pout[WIDTH-1] (LSB-first frame).
REQ-016 On the edge sampling bit WIDTH (counter = WIDTH-1), the FSM SHALL return to IDLE and the frame SHALL complete; start is ignored on that edge.
REQ-017 Latency: with start sampled at edge 0, bits are sampled at edges 1..WIDTH, and out_valid is high after edge WIDTH.
REQ-018 start SHALL be ignored while in SHIFT; a new frame needs start in IDLE, so back-to-back frames have one idle cycle between them.
REQ-019 Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1; out_valid then clears unless a frame completes on the same edge.
REQ-020 On frame completion with out_valid=0, or with out_valid=1 and out_ready=1: pout loads the new frame and out_valid=1.
REQ-021 On frame completion with out_valid=1 and out_ready=0: the new frame is dropped, pout and out_valid are unchanged, and overrun is set to 1.
REQ-022 pout SHALL stay stable while out_valid=1 and no transfer occurs.
REQ-023 overrun SHALL remain set until clr_ovr=1; if clr_ovr and a new overrun occur on the same edge, overrun stays 1.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and never exceed WIDTH-1.

Reset
REQ-025 While rst_n=0: state=IDLE, counter=0, shift register=0, pout=0, out_valid=0, busy=0, overrun=0, all asynchronously.
REQ-026 Reset asserted mid-frame SHALL discard partial bits; after release the block waits in IDLE for start.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst_n rises; no frame starts without start.

Structure
REQ-028 The shared package SHALL hold the state enum (IDLE, SHIFT) and the WIDTH default constant.
REQ-029 The shift register SHALL be one sub-module, sipo_shift_reg: WIDTH-parameterised serial-in/parallel-out with shift enable and async active-low reset. The FSM, counter, output register and flags live in sipo_frame_ctrl.

Verification (WIDTH=8)
REQ-030 Frame: start at edge 0, sin = 1,0,1,1,0,0,1,0 at edges 1..8, out_ready=0 -> out_valid=1 after edge 8, pout=8'h4D, busy high for 8 cycles.
REQ-031 Handshake: with REQ-030 state held, set out_ready=1 for one edge -> out_valid=0 next cycle; hold out_ready=0 for 20 cycles beforehand -> pout constant at 8'h4D.
REQ-032 Overrun: leave frame 8'h4D unconsumed, then receive frame 8'hFF -> pout=8'h4D, overrun=1; pulse clr_ovr -> overrun=0.
REQ-033 Simultaneous: out_ready=1 on the completion edge of frame 8'hA5 while 8'h4D is pending -> pout=8'hA5, out_valid=1, overrun=0.
REQ-034 Reset mid-frame: rst_n low after 4 bits -> all outputs 0 immediately; after release, a full frame 8'h3C completes correctly.
REQ-035 Start ignored: pulse start at bit 3 of a frame -> frame completes after exactly 8 sampled bits, and state returns to IDLE.

Source files
------------

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
package sipo_frame_ctrl_pkg;

    // Frame length used when the instantiating code does not override WIDTH.
    localparam int unsigned WIDTH_DEFAULT = 8;

    // Controller states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Handshake and data bundle between a frame producer/consumer and the controller.
interface sipo_frame_ctrl_if
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic             sin;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] pout;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    // Environment side: drives requests and serial data, observes the frame.
    modport master (
        output start, sin, out_ready, clr_ovr,
        input  pout, out_valid, busy, overrun
    );

    // Controller side.
    modport slave (
        input  start, sin, out_ready, clr_ovr,
        output pout, out_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register, new bits enter at the MSB.
module sipo_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             sin,
    // Parallel view including the bit being shifted in this cycle, so the
    // controller can capture a complete frame on the same edge as its last bit.
    output logic [WIDTH-1:0] pdata
);
    logic [WIDTH-1:0] q;

    assign pdata = {sin, q[WIDTH-1:1]};

    // Shift toward bit 0 while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= pdata;
        end
    end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH serial bits LSB-first and offers them on a
// valid/ready output; a frame completing while the previous one is unconsumed
// is dropped and flagged as overrun.
module sipo_frame_ctrl
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    sipo_frame_ctrl_if.slave  bus
);
    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic             busy_r;
    logic [WIDTH-1:0] frame;
    logic [WIDTH-1:0] pout_r;
    logic             valid_r;
    logic             ovr_r;

    logic shift_en;
    logic done;
    logic accept;
    logic drop;

    assign shift_en = (state == SHIFT);
    assign done     = shift_en && (cnt == CntLast);
    assign accept   = done && (!valid_r || bus.out_ready);
    assign drop     = done && valid_r && !bus.out_ready;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .sin      (bus.sin),
        .pdata    (frame)
    );

    // Sequencing FSM with bit counter; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CntLast) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register, handshake and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout_r  <= '0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (accept) begin
                pout_r  <= frame;
                valid_r <= 1'b1;
            end else if (valid_r && bus.out_ready) begin
                valid_r <= 1'b0;
            end
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                ovr_r <= 1'b1;
            end else if (bus.clr_ovr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign bus.pout      = pout_r;
    assign bus.out_valid = valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = ovr_r;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl at WIDTH=8.
module tb_sipo_frame_ctrl;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [7:0] exp_q[$];

    sipo_frame_ctrl_if #(.WIDTH(8)) bus ();

    sipo_frame_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer must deliver the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_transfer: got %0h expected none", bus.pout);
            end else begin
                check("transfer_pout", {24'd0, bus.pout}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and feed it LSB first; optionally pulse start at bit
    // start_at and raise out_ready on the completion edge.
    task automatic send_frame(input logic [7:0] f, input int start_at, input bit ready_last,
                              output int busy_cycles);
        busy_cycles = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy) busy_cycles++;
            bus.sin   = f[i];
            bus.start = (i == start_at);
            if (ready_last && i == 7) bus.out_ready = 1'b1;
            tick();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pout"}, {24'd0, bus.pout}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.sin       = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovr   = 1'b0;

        // Reset state and idle after release.
        #12;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_start_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_no_start_valid", {31'd0, bus.out_valid}, 32'd0);

        // Basic frame 8'h4D, left pending.
        exp_q.push_back(8'h4D);
        send_frame(8'h4D, -1, 1'b0, bc);
        check("f4d_busy_cycles", bc, 32'd8);
        check("f4d_busy_after", {31'd0, bus.busy}, 32'd0);
        check("f4d_valid", {31'd0, bus.out_valid}, 32'd1);
        check("f4d_pout", {24'd0, bus.pout}, 32'h4D);

        // Hold without ready: pout must not move.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_pout", {24'd0, bus.pout}, 32'h4D);
        end
        drain();
        check("after_xfer_valid", {31'd0, bus.out_valid}, 32'd0);

        // Overrun: 4D pending, FF dropped, then cleared.
        exp_q.push_back(8'h4D);
        send_frame(8'h4D, -1, 1'b0, bc);
        send_frame(8'hFF, -1, 1'b0, bc);
        check("ovr_pout", {24'd0, bus.pout}, 32'h4D);
        check("ovr_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ovr_flag", {31'd0, bus.overrun}, 32'd1);
        tick();
        check("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        check("ovr_cleared", {31'd0, bus.overrun}, 32'd0);

        // Simultaneous transfer and completion: 4D leaves, A5 loads.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, -1, 1'b1, bc);
        check("simul_pout", {24'd0, bus.pout}, 32'hA5);
        check("simul_valid", {31'd0, bus.out_valid}, 32'd1);
        check("simul_overrun", {31'd0, bus.overrun}, 32'd0);
        drain();
        check("simul_drained", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-frame with an unconsumed frame and overrun set.
        send_frame(8'h96, -1, 1'b0, bc);
        send_frame(8'h11, -1, 1'b0, bc);
        check("pre_rst_overrun", {31'd0, bus.overrun}, 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sin = i[0];
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, -1, 1'b0, bc);
        check("f3c_busy_cycles", bc, 32'd8);
        check("f3c_pout", {24'd0, bus.pout}, 32'h3C);
        drain();

        // start pulsed at bit 3 is ignored.
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 3, 1'b0, bc);
        check("ign_busy_cycles", bc, 32'd8);
        check("ign_idle", {31'd0, bus.busy}, 32'd0);
        check("ign_pout", {24'd0, bus.pout}, 32'h5A);
        tick();
        check("ign_still_idle", {31'd0, bus.busy}, 32'd0);
        drain();

        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
